// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM access controller.
// Holds the FSM state encoding, the default geometry of the attached
// 1024x8 RAM, and the bulk-init fill pattern.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 1024;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    IDLE     = 3'd1,
    WR       = 3'd2,
    RD       = 3'd3,
    GAP      = 3'd4,
    INIT_WR  = 3'd5,
    INIT_GAP = 3'd6
  } state_t;

  // Fill value for one location: (2*addr) mod 2^data_w. The 64-bit
  // intermediate keeps the doubling and the mask free of overflow.
  function automatic logic [31:0] init_pattern(input logic [31:0] addr,
                                               input int          data_w);
    logic [63:0] twice;
    logic [63:0] mask;
    twice = {31'd0, addr, 1'b0};
    mask  = (64'd1 << data_w) - 64'd1;
    return 32'(twice & mask);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response channel of the RAM access controller.
//   req_valid/req_ready : request handshake
//   req_write           : 1 = write, 0 = read
//   req_addr/req_wdata  : request address and write data
//   rsp_valid/rsp_data  : one-cycle read response pulse and held read data
// master = requester side, slave = controller side.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_init_seq.sv
// Bulk-init address sequencer.
//   clk, reset : clock and asynchronous active-high reset
//   step       : advance to the next location (asserted once per init write)
//   clear      : return to address 0 and drop the done flag
//   cnt        : address of the next location to fill
//   pattern    : fill value for cnt
//   done       : the location just stepped past was the last one
module ram_init_seq
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              clear,
  output logic [ADDR_W-1:0] cnt,
  output logic [DATA_W-1:0] pattern,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  // The done flag is captured when stepping off the last address, so the
  // FSM can decide in the gap cycle even though cnt has already moved on
  // (or wrapped when DEPTH fills the whole address space).
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clear) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (step) begin
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_q == LAST_ADDR);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt     = cnt_q;
  assign done    = done_q;
  assign pattern = DATA_W'(init_pattern(32'(cnt_q), DATA_W));

endmodule

// File: rtl/ram_access_ctrl.sv
// Front-end controller for a single-port RAM with combinational read.
// Accepts one read or write at a time, drives registered RAM strobes with a
// de-assert cycle between accesses, returns read data as a one-cycle pulse,
// and can fill the whole RAM with (2*addr) mod 2^DATA_W.
//   clk, reset     : clock and asynchronous active-high reset
//   req            : request/response channel (slave side)
//   init_start     : start a bulk init (only honoured in IDLE)
//   init_busy      : bulk init in progress
//   ram_address, ram_data_in, ram_write, ram_select : registered RAM pins
//   ram_data_out   : RAM read data
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  ram_access_ctrl_if.slave  req,
  input  logic              init_start,
  output logic              init_busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write,
  output logic              ram_select,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
  logic              ram_write_q, ram_write_d;
  logic              ram_select_q, ram_select_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              req_ready_c;
  logic              accept;
  logic              seq_step;
  logic              seq_clear;
  logic [ADDR_W-1:0] seq_cnt;
  logic [DATA_W-1:0] seq_pattern;
  logic              seq_done;

  ram_init_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clk     (clk),
    .reset   (reset),
    .step    (seq_step),
    .clear   (seq_clear),
    .cnt     (seq_cnt),
    .pattern (seq_pattern),
    .done    (seq_done)
  );

  // Next-state logic, followed by a decode of the next state into the RAM
  // pin registers, so the strobes are flop outputs that are high exactly
  // while the FSM sits in WR/RD/INIT_WR. init_start beats a pending request.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    ram_write_d   = 1'b0;
    ram_select_d  = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    seq_step      = 1'b0;
    seq_clear     = 1'b0;
    req_ready_c   = (state_q == IDLE) && !init_start;
    accept        = req_ready_c && req.req_valid;

    case (state_q)
      BOOT:     state_d = INIT_ON_RESET ? INIT_WR : IDLE;
      IDLE: begin
        if (init_start) begin
          state_d = INIT_WR;
        end else if (accept) begin
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          write_d = req.req_write;
          state_d = req.req_write ? WR : RD;
        end
      end
      WR:       state_d = GAP;
      GAP:      state_d = IDLE;
      RD: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = ram_data_out;
        state_d     = IDLE;
      end
      INIT_WR: begin
        seq_step = 1'b1;
        state_d  = INIT_GAP;
      end
      INIT_GAP: begin
        if (seq_done) begin
          seq_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = INIT_WR;
        end
      end
      default:  state_d = BOOT;
    endcase

    case (state_d)
      WR, RD: begin
        ram_select_d  = 1'b1;
        ram_write_d   = write_d;
        ram_address_d = addr_d;
        if (write_d) ram_data_in_d = wdata_d;
      end
      INIT_WR: begin
        ram_select_d  = 1'b1;
        ram_write_d   = 1'b1;
        ram_address_d = seq_cnt;
        ram_data_in_d = seq_pattern;
      end
      default: ;
    endcase
  end

  // All state, latched request fields and RAM pins; reset drops the
  // strobes immediately and discards any pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_write_q   <= 1'b0;
      ram_select_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      ram_write_q   <= ram_write_d;
      ram_select_q  <= ram_select_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign req.req_ready = req_ready_c;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_data  = rsp_data_q;
  assign init_busy     = (state_q == INIT_WR) || (state_q == INIT_GAP);
  assign ram_address   = ram_address_q;
  assign ram_data_in   = ram_data_in_q;
  assign ram_write     = ram_write_q;
  assign ram_select    = ram_select_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a behavioural 1024x8 RAM.
// Expected read data comes from a reference memory image kept here, which
// is filled with (2*addr)%256 after every completed init and updated on
// every accepted write; expected response timing is accept edge + 1.
module tb_ram_access_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;

  typedef struct {
    int data;
    int cyc;
  } rsp_t;

  logic              clk;
  logic              reset;
  logic              initStart;
  logic              initBusy;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramDataIn;
  logic              ramWrite;
  logic              ramSelect;
  logic [DATA_W-1:0] ramDataOut;
  logic [DATA_W-1:0] ramMem [DEPTH];

  ram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) reqIf ();

  ram_access_ctrl #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (reqIf),
    .init_start   (initStart),
    .init_busy    (initBusy),
    .ram_address  (ramAddress),
    .ram_data_in  (ramDataIn),
    .ram_write    (ramWrite),
    .ram_select   (ramSelect),
    .ram_data_out (ramDataOut)
  );

  int   testsRun = 0;
  int   failCount = 0;
  int   edgeCount = 0;
  int   refMem [DEPTH];
  rsp_t expQ [$];
  rsp_t rspQ [$];

  // Monitor state, written only by the monitor process.
  int initIdx = 0;
  int initBusyCycles = 0;
  int initWrites = 0;
  int initBad = 0;
  int readyInInit = 0;
  int gapErr = 0;
  int rspWidthErr = 0;
  bit prevSel = 0;
  bit prevRsp = 0;

  // Snapshots taken before an init so its own totals can be isolated.
  int snapBusy, snapWrites, snapBad, snapReady;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Behavioural RAM: combinational read, write on the rising edge.
  assign ramDataOut = ramMem[ramAddress];
  always @(posedge clk) begin
    if (ramSelect && ramWrite) ramMem[ramAddress] <= ramDataIn;
  end

  // Mid-cycle monitor: init write sequence, strobe gaps, response pulses.
  always @(negedge clk) begin
    if (reset) begin
      initIdx = 0;
      prevSel = 0;
      prevRsp = 0;
    end else begin
      if (initBusy) initBusyCycles++;
      if (initBusy && reqIf.req_ready) readyInInit++;
      if (initBusy && ramSelect && ramWrite) begin
        if (int'(ramAddress) != initIdx || int'(ramDataIn) != (2 * initIdx) % 256) initBad++;
        initIdx++;
        initWrites++;
      end
      if (!initBusy) initIdx = 0;
      if (prevSel && ramSelect) gapErr++;
      if (prevRsp && reqIf.rsp_valid) rspWidthErr++;
      if (reqIf.rsp_valid) rspQ.push_back('{data: int'(reqIf.rsp_data), cyc: edgeCount});
      prevSel = ramSelect;
      prevRsp = reqIf.rsp_valid;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic syncCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    reqIf.req_valid = 1'b0;
  endtask

  task automatic fillRef();
    for (int a = 0; a < DEPTH; a++) refMem[a] = (2 * a) % 256;
  endtask

  task automatic initSnapshot();
    snapBusy   = initBusyCycles;
    snapWrites = initWrites;
    snapBad    = initBad;
    snapReady  = readyInInit;
  endtask

  // Present a request (caller is just past a rising edge) and hold it until
  // accepted; returns just past the accepting edge with the fields still up.
  task automatic applyStimulus(input bit wr, input int addr, input int data, output int acceptEdge);
    int waited;
    reqIf.req_valid = 1'b1;
    reqIf.req_write = wr;
    reqIf.req_addr  = addr[ADDR_W-1:0];
    reqIf.req_wdata = data[DATA_W-1:0];
    acceptEdge = -1;
    waited = 0;
    while (waited < 6000) begin
      @(negedge clk);
      if (reqIf.req_ready) break;
      waited++;
    end
    if (waited >= 6000) begin
      checkOutput("acceptTimeout", 0, 1);
      return;
    end
    @(posedge clk);
    #1;
    acceptEdge = edgeCount;
    if (wr) refMem[addr] = data % 256;
    else expQ.push_back('{data: refMem[addr], cyc: acceptEdge + 1});
  endtask

  task automatic waitInitDone(input string tag);
    int  budget;
    bit  seen;
    seen = 0;
    for (budget = 0; budget < 6000; budget++) begin
      @(negedge clk);
      if (initBusy) seen = 1;
      else if (seen) break;
    end
    checkOutput({tag, "_initFinished"}, 32'(budget < 6000), 1);
    checkOutput({tag, "_busyCycles"}, initBusyCycles - snapBusy, 2 * DEPTH);
    checkOutput({tag, "_initWrites"}, initWrites - snapWrites, DEPTH);
    checkOutput({tag, "_initBadWrites"}, initBad - snapBad, 0);
    checkOutput({tag, "_readyDuringInit"}, readyInInit - snapReady, 0);
    fillRef();
  endtask

  task automatic drainResponses(input string tag);
    int   budget;
    rsp_t e;
    rsp_t r;
    budget = 0;
    while (rspQ.size() < expQ.size() && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (rspQ.size() == 0) begin
        checkOutput({tag, "_rspMissing"}, 0, 1);
      end else begin
        r = rspQ.pop_front();
        checkOutput({tag, "_rspData"}, r.data, e.data);
        checkOutput({tag, "_rspCycle"}, r.cyc, e.cyc);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput({tag, "_extraRsp"}, rspQ.size(), 0);
    rspQ.delete();
  endtask

  initial begin
    int a1, a2, a3;
    int found;
    bit wr;
    int addr;
    int data;

    reset = 1'b1;
    initStart = 1'b0;
    reqIf.req_valid = 1'b0;
    reqIf.req_write = 1'b0;
    reqIf.req_addr  = '0;
    reqIf.req_wdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_select", ramSelect, 0);
    checkOutput("rst_write", ramWrite, 0);
    checkOutput("rst_address", ramAddress, 0);
    checkOutput("rst_dataIn", ramDataIn, 0);
    checkOutput("rst_initBusy", initBusy, 0);
    checkOutput("rst_reqReady", reqIf.req_ready, 0);
    checkOutput("rst_rspValid", reqIf.rsp_valid, 0);

    // Automatic init after reset release.
    initSnapshot();
    @(posedge clk);
    #1 reset = 1'b0;
    waitInitDone("boot");

    // Reads of initialised locations.
    syncCycle();
    applyStimulus(0, 5, 0, a1);
    applyStimulus(0, 200, 0, a1);
    idleBus();
    drainResponses("initRead");

    // Write strobe shape and ready hold-off, then readback.
    syncCycle();
    applyStimulus(1, 1023, 8'hA5, a1);
    idleBus();
    @(negedge clk);
    checkOutput("wr_ready1", reqIf.req_ready, 0);
    checkOutput("wr_write1", ramWrite, 1);
    checkOutput("wr_select1", ramSelect, 1);
    checkOutput("wr_address", ramAddress, 1023);
    checkOutput("wr_dataIn", ramDataIn, 8'hA5);
    @(negedge clk);
    checkOutput("wr_ready2", reqIf.req_ready, 0);
    checkOutput("wr_write2", ramWrite, 0);
    checkOutput("wr_select2", ramSelect, 0);
    @(negedge clk);
    checkOutput("wr_ready3", reqIf.req_ready, 1);
    syncCycle();
    applyStimulus(0, 1023, 0, a1);
    idleBus();
    drainResponses("wrReadback");

    // Back-to-back reads with req_valid held.
    syncCycle();
    applyStimulus(0, 0, 0, a1);
    applyStimulus(0, 1, 0, a2);
    applyStimulus(0, 2, 0, a3);
    idleBus();
    checkOutput("b2b_spacing1", a2 - a1, 2);
    checkOutput("b2b_spacing2", a3 - a2, 2);
    drainResponses("b2b");

    // init_start and a request together: init wins, request waits.
    syncCycle();
    applyStimulus(1, 7, 8'h3C, a1);
    idleBus();
    repeat (2) syncCycle();
    initSnapshot();
    initStart = 1'b1;
    reqIf.req_valid = 1'b1;
    reqIf.req_write = 1'b0;
    reqIf.req_addr  = 10'd7;
    @(negedge clk);
    checkOutput("prio_readyLow", reqIf.req_ready, 0);
    @(posedge clk);
    #1 initStart = 1'b0;
    waitInitDone("prio");
    checkOutput("prio_readyAfterInit", reqIf.req_ready, 1);
    @(posedge clk);
    #1;
    expQ.push_back('{data: refMem[7], cyc: edgeCount + 1});
    idleBus();
    drainResponses("prioRead");

    // init_start during RD is ignored.
    syncCycle();
    applyStimulus(0, 9, 0, a1);
    idleBus();
    initStart = 1'b1;
    syncCycle();
    initStart = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rdInit_busy", initBusy, 0);
    end
    drainResponses("rdInit");

    // Randomised mix of reads and writes against the reference image.
    syncCycle();
    for (int i = 0; i < 60; i++) begin
      wr   = 1'($urandom % 2);
      addr = int'($urandom_range(0, DEPTH - 1));
      data = int'($urandom % 256);
      if (i % 5 == 0) addr = 1023 - (i % 3);
      applyStimulus(wr, addr, data, a1);
      if ($urandom % 4 == 0) begin
        idleBus();
        repeat ($urandom_range(1, 3)) syncCycle();
      end
    end
    idleBus();
    drainResponses("random");

    // Reset in the middle of init, while address 300 is being written.
    syncCycle();
    initStart = 1'b1;
    syncCycle();
    initStart = 1'b0;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (initBusy && ramSelect && ramAddress == 10'd300) begin
        found = 1;
        break;
      end
    end
    checkOutput("midInit_reached300", found, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midInit_select", ramSelect, 0);
    checkOutput("midInit_write", ramWrite, 0);
    checkOutput("midInit_busy", initBusy, 0);
    repeat (2) @(posedge clk);
    initSnapshot();
    #1 reset = 1'b0;
    waitInitDone("midInit");

    // Reset in the middle of a write.
    syncCycle();
    applyStimulus(1, 300, 8'h33, a1);
    checkOutput("midWr_writeUp", ramWrite, 1);
    reset = 1'b1;
    #1;
    checkOutput("midWr_select", ramSelect, 0);
    checkOutput("midWr_write", ramWrite, 0);
    idleBus();
    repeat (2) @(posedge clk);
    initSnapshot();
    #1 reset = 1'b0;
    waitInitDone("midWr");
    syncCycle();
    applyStimulus(0, 300, 0, a1);
    idleBus();
    drainResponses("final300");

    checkOutput("strobeGap", gapErr, 0);
    checkOutput("rspWidth", rspWidthErr, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
